// File: rtl/repeated_add_multiplier.sv
// repeated_add_multiplier: unsigned A*B by adding A into P B times; operands load serially on data_in.
module repeated_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             done,
  output logic [WIDTH-1:0] Y
);
  localparam logic [2:0] IDLE = 3'd0, LOAD_A = 3'd1, LOAD_B = 3'd2, MULT = 3'd3, DONE = 3'd4;
  logic [2:0] state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d;
  logic ld_a, ld_b, clr_p, ld_p, dec_b, eq_z;
  assign eq_z  = b_q == '0;
  assign ld_a  = state_q == LOAD_A;
  assign ld_b  = state_q == LOAD_B;
  assign clr_p = ld_b;
  assign ld_p  = state_q == MULT && !eq_z;
  assign dec_b = ld_p;
  assign done  = state_q == DONE;
  assign Y     = p_q;
  // unused state codes fall back to IDLE
  always_comb begin
    state_d = state_q == IDLE   ? (start ? LOAD_A : IDLE) :
              state_q == LOAD_A ? LOAD_B :
              state_q == LOAD_B ? MULT :
              state_q == MULT   ? (eq_z ? DONE : MULT) :
              state_q == DONE   ? (start ? DONE : IDLE) : IDLE;
    a_d = ld_a ? data_in : a_q;
    b_d = ld_b ? data_in : dec_b ? b_q - WIDTH'(1) : b_q;
    p_d = clr_p ? '0 : ld_p ? p_q + a_q : p_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
    end
  end
endmodule

// File: tb/tb_repeated_add_multiplier.sv
// tb_repeated_add_multiplier: random and directed transactions checked every cycle against an arithmetic model.
module tb_repeated_add_multiplier;
  logic        clk = 0, rst = 1, start = 0;
  logic [15:0] data_in = '0;
  logic        done;
  logic [15:0] Y;
  int n_chk = 0, n_err = 0;
  bit chk_en = 0;
  bit lit_valid = 0;
  string lit_name = "";
  int lit_act = 0, lit_exp = 0;
  int m_k = -1;
  logic [15:0] m_a = '0, m_b = '0, m_held = '0;

  repeated_add_multiplier #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .done(done), .Y(Y)
  );

  always #5 clk = ~clk;

  // model: m_k counts edges since start was sampled in idle; -1 means idle
  always @(posedge clk) begin
    if (rst) begin
      m_k = -1;
      m_held = '0;
    end else if (m_k < 0) begin
      if (start) m_k = 0;
    end else if (m_k >= 3 + int'(m_b) && !start) begin
      m_k = -1;
      m_held = prod(m_a, m_b);
    end else begin
      m_k++;
      if (m_k == 1) m_a = data_in;
      if (m_k == 2) m_b = data_in;
    end
  end

  function automatic logic [15:0] prod(input logic [15:0] a, input longint n);
    longint t;
    t = longint'(a) * n;
    return t[15:0];
  endfunction

  function automatic logic [15:0] exp_y();
    if (m_k < 2) return m_held;
    if (m_k == 2) return '0;
    if (m_k < 3 + int'(m_b)) return prod(m_a, longint'(m_k - 2));
    return prod(m_a, longint'(m_b));
  endfunction

  function automatic logic exp_done();
    return m_k >= 3 && m_k >= 3 + int'(m_b);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("Y", 32'(Y), 32'(exp_y()));
      chk("done", 32'(done), 32'(exp_done()));
    end
    if (lit_valid) chk(lit_name, lit_act, lit_exp);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int act, input int exp);
    lit_name = name;
    lit_act = act;
    lit_exp = exp;
    lit_valid = 1;
    cyc();
    lit_valid = 0;
  endtask

  task automatic mult(input logic [15:0] a, input logic [15:0] b, input bit noise, input bit hold);
    int n;
    start = 1;
    if (noise) data_in = 16'($urandom);
    cyc();
    data_in = a;
    start = noise ? 1'($urandom) : 1'b0;
    cyc();
    data_in = b;
    start = noise ? 1'($urandom) : 1'b0;
    cyc();
    n = 2;
    while (!done && n < 400) begin
      if (noise) begin
        data_in = 16'($urandom);
        start = 1'($urandom);
      end
      cyc();
      n++;
    end
    start = hold;
    if (!done) lit("done_timeout", int'(done), 1);
    else lit("done_edge", n, 3 + int'(b));
  endtask

  initial begin
    cyc();
    chk_en = 1;
    cyc();
    rst = 0;
    lit("reset_Y", int'(Y), 0);
    lit("reset_done", int'(done), 0);
    mult(16'd17, 16'd5, 0, 0);
    lit("17x5", int'(Y), 85);
    mult(16'd1234, 16'd0, 0, 0);
    lit("1234x0", int'(Y), 0);
    mult(16'd0, 16'd7, 0, 0);
    lit("0x7", int'(Y), 0);
    mult(16'd300, 16'd300, 0, 0);
    lit("300x300_wrap", int'(Y), 24464);
    start = 1;
    cyc();
    data_in = 16'd17;
    start = 0;
    cyc();
    data_in = 16'd5;
    cyc();
    for (int i = 0; i < 20 && Y != 16'd34; i++) cyc();
    lit("mid_Y34", int'(Y), 34);
    rst = 1;
    cyc();
    rst = 0;
    lit("midrst_Y", int'(Y), 0);
    lit("midrst_done", int'(done), 0);
    mult(16'd17, 16'd5, 0, 0);
    lit("after_rst_17x5", int'(Y), 85);
    mult(16'd9, 16'd6, 0, 1);
    for (int i = 0; i < 5; i++) cyc();
    lit("hold_done", int'(done), 1);
    lit("hold_Y", int'(Y), 54);
    start = 0;
    cyc();
    cyc();
    lit("drop_done", int'(done), 0);
    lit("drop_Y", int'(Y), 54);
    mult(16'd3, 16'd4, 0, 0);
    lit("3x4", int'(Y), 12);
    for (int i = 0; i < 20; i++) begin
      mult(16'($urandom), 16'($urandom_range(0, 40)), 1, 1'($urandom));
      start = 0;
      data_in = 16'($urandom);
      repeat ($urandom_range(1, 3)) cyc();
    end
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
